// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file constants and types for the write-back arbiter slice.
package regfile_wb_arbiter_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [NUM_REGS-1:0]   reg_vec_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Requester, reservation and register-file write bundle around the write-back arbiter.
interface regfile_wb_arbiter_if
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NREQ   = 3,
  parameter int DATA_W = 32
);
  logic [NREQ-1:0]             req_valid;
  reg_addr_t [NREQ-1:0]        req_addr;
  logic [NREQ-1:0][DATA_W-1:0] req_data;
  logic [NREQ-1:0]             req_ready;
  logic                        rsv_valid;
  reg_addr_t                   rsv_addr;
  reg_vec_t                    busy;
  logic                        wb_en;
  reg_addr_t                   wb_addr;
  logic [DATA_W-1:0]           wb_data;

  modport master (
    output req_valid, req_addr, req_data, rsv_valid, rsv_addr,
    input  req_ready, busy, wb_en, wb_addr, wb_data
  );
  modport slave (
    input  req_valid, req_addr, req_data, rsv_valid, rsv_addr,
    output req_ready, busy, wb_en, wb_addr, wb_data
  );
endinterface

// File: rtl/decode5.sv
// 5-to-32 one-hot decoder with enable; all-zero output when disabled.
module decode5
  import regfile_wb_arbiter_pkg::*;
(
  input  logic      en,
  input  reg_addr_t addr,
  output reg_vec_t  onehot
);
  always_comb begin
    onehot       = '0;
    onehot[addr] = en;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the single register-file write port,
// plus the pending-write scoreboard used by issue for RAW stalls.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREQ   = 3
)(
  input logic                 clk,
  input logic                 reset,
  regfile_wb_arbiter_if.slave bus
);
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef logic [PTR_W-1:0] ptr_t;

  ptr_t              ptr_q, ptr_d, gnt_idx, hi_idx;
  logic              gnt_any, hi_any;
  reg_addr_t         gnt_addr;
  logic [DATA_W-1:0] gnt_data;
  reg_vec_t          set_vec, clr_vec, busy_q, busy_d;
  logic              wb_en_q, wb_en_d;
  reg_addr_t         wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  // Masked priority encoder: lowest valid index >= ptr, else lowest valid overall.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    hi_any  = 1'b0;
    hi_idx  = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        gnt_any = 1'b1;
        gnt_idx = ptr_t'(i);
        if (ptr_t'(i) >= ptr_q) begin
          hi_any = 1'b1;
          hi_idx = ptr_t'(i);
        end
      end
    end
    if (hi_any) gnt_idx = hi_idx;
  end

  always_comb begin
    bus.req_ready = '0;
    if (gnt_any) bus.req_ready[gnt_idx] = 1'b1;
  end

  assign gnt_addr = bus.req_addr[gnt_idx];
  assign gnt_data = bus.req_data[gnt_idx];

  decode5 u_set_dec (.en(bus.rsv_valid), .addr(bus.rsv_addr), .onehot(set_vec));
  decode5 u_clr_dec (.en(gnt_any),       .addr(gnt_addr),     .onehot(clr_vec));

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (gnt_idx == ptr_t'(NREQ-1)) ? '0 : gnt_idx + ptr_t'(1);
    // Set after clear: a fresh reservation outlives the older write retiring now.
    busy_d    = (busy_q & ~clr_vec) | set_vec;
    busy_d[0] = 1'b0;
    wb_en_d   = gnt_any && (gnt_addr != ZERO_REG);
    wb_addr_d = gnt_any ? gnt_addr : wb_addr_q;
    wb_data_d = gnt_any ? gnt_data : wb_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q     <= '0;
      busy_q    <= '0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      busy_q    <= busy_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.wb_en   = wb_en_q;
  assign bus.wb_addr = wb_addr_q;
  assign bus.wb_data = wb_data_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus a randomized run against a queue-free behavioural model.
module tb_regfile_wb_arbiter;
  localparam int NREQ   = 3;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W)) bus();
  regfile_wb_arbiter #(.DATA_W(DATA_W), .NREQ(NREQ)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // behavioural model state
  int               m_ptr = 0, m_g = -1, m_last_g = -1;
  logic             m_wb_en = 1'b0;
  logic [4:0]       m_wb_addr = '0;
  logic [31:0]      m_wb_data = '0;
  logic [31:0]      m_busy = '0;
  logic [NREQ-1:0]  m_ready;
  // requester-rule tracking
  logic [NREQ-1:0]  pend = '0;
  logic [4:0]       pend_addr [NREQ];
  logic [31:0]      pend_data [NREQ];

  task automatic model_comb();
    m_g = -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx = (m_ptr + k) % NREQ;
      if (m_g < 0 && bus.req_valid[idx]) m_g = idx;
    end
    m_ready = '0;
    if (m_g >= 0) m_ready[m_g] = 1'b1;
  endtask

  task automatic model_clk();
    if (reset) begin
      m_ptr = 0; m_wb_en = 1'b0; m_wb_addr = '0; m_wb_data = '0; m_busy = '0; m_last_g = -1;
    end else begin
      m_last_g = m_g;
      if (m_g >= 0) begin
        m_ptr     = (m_g + 1) % NREQ;
        m_wb_addr = bus.req_addr[m_g];
        m_wb_data = bus.req_data[m_g];
        m_wb_en   = (bus.req_addr[m_g] != 5'd0);
        m_busy[bus.req_addr[m_g]] = 1'b0;
      end else begin
        m_wb_en = 1'b0;
      end
      if (bus.rsv_valid) m_busy[bus.rsv_addr] = 1'b1;
      m_busy[0] = 1'b0;
    end
  endtask

  // Advance one cycle: inputs are changed only at the negedge, outputs compared at the negedge.
  task automatic tick();
    model_comb();
    for (int i = 0; i < NREQ; i++)
      if (pend[i] && !reset)
        assert (bus.req_valid[i] && bus.req_addr[i] == pend_addr[i] && bus.req_data[i] == pend_data[i])
          else $error("requester %0d dropped or changed a pending request", i);
    @(posedge clk);
    model_clk();
    for (int i = 0; i < NREQ; i++) begin
      pend[i]      = bus.req_valid[i] && (m_last_g != i);
      pend_addr[i] = bus.req_addr[i];
      pend_data[i] = bus.req_data[i];
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.req_valid = '0;
    bus.rsv_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = '1;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_addr[i] = 5'(i + 1);
      bus.req_data[i] = $urandom;
    end
    tick(); tick();
    checks++; if (bus.wb_en !== 1'b0) begin errors++; $display("FAIL reset_wb_en got %b exp 0", bus.wb_en); end
    checks++; if (bus.busy !== 32'h0) begin errors++; $display("FAIL reset_busy got %h exp 0", bus.busy); end
    checks++; if (bus.wb_addr !== 5'd0 || bus.wb_data !== 32'h0) begin
      errors++; $display("FAIL reset_wb_regs got addr %0d data %h exp 0/0", bus.wb_addr, bus.wb_data); end
    reset = 1'b0;
    #1; model_comb();
    checks++; if (bus.req_ready !== 3'b001 || bus.req_ready !== m_ready) begin
      errors++; $display("FAIL reset_first_grant got %b exp 001", bus.req_ready); end
  endtask

  task automatic test_round_robin();
    logic [31:0] d [NREQ];
    logic [NREQ-1:0] exp_r;
    apply_reset();
    bus.req_valid = '1;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_addr[i] = 5'(5 + i);
      d[i] = $urandom;
      bus.req_data[i] = d[i];
    end
    for (int c = 0; c < 4; c++) begin
      exp_r = '0; exp_r[c % 3] = 1'b1;
      #1; model_comb();
      checks++; if (bus.req_ready !== exp_r || m_ready !== exp_r) begin
        errors++; $display("FAIL rr_grant c=%0d got %b exp %b", c, bus.req_ready, exp_r); end
      tick();
      checks++; if (bus.wb_en !== 1'b1 || bus.wb_addr !== 5'(5 + c % 3) || bus.wb_data !== d[c % 3]) begin
        errors++; $display("FAIL rr_wb c=%0d got en %b addr %0d data %h exp 1/%0d/%h",
                           c, bus.wb_en, bus.wb_addr, bus.wb_data, 5 + c % 3, d[c % 3]); end
    end
    bus.req_valid = '0;
  endtask

  task automatic test_zero();
    apply_reset();
    bus.req_valid = 3'b010;
    bus.req_addr[1] = 5'd0;
    bus.req_data[1] = 32'hDEADBEEF;
    #1;
    checks++; if (bus.req_ready !== 3'b010) begin errors++; $display("FAIL zero_grant got %b exp 010", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    checks++; if (bus.wb_en !== 1'b0 || bus.busy[0] !== 1'b0) begin
      errors++; $display("FAIL zero_consumed got en %b busy0 %b exp 0/0", bus.wb_en, bus.busy[0]); end
    checks++; if (bus.wb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL zero_data got %h exp deadbeef", bus.wb_data); end
  endtask

  task automatic test_scoreboard();
    apply_reset();
    bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd9;
    tick();
    bus.rsv_valid = 1'b0;
    checks++; if (bus.busy !== 32'h0000_0200) begin errors++; $display("FAIL sb_set got %h exp 00000200", bus.busy); end
    bus.req_valid = 3'b100; bus.req_addr[2] = 5'd9; bus.req_data[2] = $urandom;
    #1;
    checks++; if (bus.req_ready !== 3'b100) begin errors++; $display("FAIL sb_grant got %b exp 100", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    checks++; if (bus.busy[9] !== 1'b0 || bus.wb_en !== 1'b1 || bus.wb_addr !== 5'd9) begin
      errors++; $display("FAIL sb_clear got busy9 %b en %b addr %0d exp 0/1/9", bus.busy[9], bus.wb_en, bus.wb_addr); end
  endtask

  task automatic test_collision();
    apply_reset();
    bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd12;
    tick();
    checks++; if (bus.busy[12] !== 1'b1) begin errors++; $display("FAIL col_pre got %b exp 1", bus.busy[12]); end
    bus.req_valid = 3'b001; bus.req_addr[0] = 5'd12; bus.req_data[0] = $urandom;
    tick();
    bus.req_valid = '0; bus.rsv_valid = 1'b0;
    checks++; if (bus.busy[12] !== 1'b1 || bus.wb_en !== 1'b1 || bus.wb_addr !== 5'd12) begin
      errors++; $display("FAIL col_set_wins got busy12 %b en %b addr %0d exp 1/1/12", bus.busy[12], bus.wb_en, bus.wb_addr); end
  endtask

  task automatic test_stall_hold();
    logic [31:0] last;
    apply_reset();
    bus.req_valid = 3'b100; bus.req_addr[2] = 5'd17;
    for (int c = 0; c < 4; c++) begin
      last = $urandom;
      bus.req_data[2] = last;
      #1;
      checks++; if (bus.req_ready !== 3'b100) begin errors++; $display("FAIL hold_grant c=%0d got %b exp 100", c, bus.req_ready); end
      tick();
      checks++; if (bus.wb_en !== 1'b1 || bus.wb_data !== last) begin
        errors++; $display("FAIL hold_write c=%0d got en %b data %h exp 1/%h", c, bus.wb_en, bus.wb_data, last); end
    end
    bus.req_valid = '0;
    tick();
    checks++; if (bus.wb_en !== 1'b0 || bus.wb_data !== last) begin
      errors++; $display("FAIL hold_idle got en %b data %h exp 0/%h", bus.wb_en, bus.wb_data, last); end
    bus.req_valid = '1;
    #1;
    checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL hold_ptr_wrap got %b exp 001", bus.req_ready); end
    bus.req_valid = '0;
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!bus.req_valid[i] || m_last_g == i) begin
          bus.req_valid[i] = ($urandom_range(0, 9) < 6);
          bus.req_addr[i]  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
          bus.req_data[i]  = $urandom;
        end
      bus.rsv_valid = ($urandom_range(0, 1) == 1);
      bus.rsv_addr  = 5'($urandom_range(0, 31));
      reset         = ($urandom_range(0, 49) == 0);
      #1; model_comb();
      checks++; if (bus.req_ready !== m_ready) begin
        errors++; $display("FAIL rnd_ready c=%0d got %b exp %b", c, bus.req_ready, m_ready); end
      tick();
      checks++; if (bus.wb_en !== m_wb_en || bus.wb_addr !== m_wb_addr || bus.wb_data !== m_wb_data) begin
        errors++; $display("FAIL rnd_wb c=%0d got %b/%0d/%h exp %b/%0d/%h", c, bus.wb_en, bus.wb_addr,
                           bus.wb_data, m_wb_en, m_wb_addr, m_wb_data); end
      checks++; if (bus.busy !== m_busy) begin
        errors++; $display("FAIL rnd_busy c=%0d got %h exp %h", c, bus.busy, m_busy); end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.rsv_valid = 1'b0;
    bus.rsv_addr  = '0;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_zero();
    test_scoreboard();
    test_collision();
    test_stall_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
